data_mem_bridge: RTL

- Sits between the riscv_core LSU data port (req/gnt/rvalid protocol) and the byte-writable single-port data BRAM.
- Converts byte addresses to word addresses and range-checks them against the RAM window.
- Drives the 1-cycle-latency RAM port and returns exactly one rvalid per granted request, in order.
- Out-of-window accesses are completed with data_err_o instead of touching RAM.

---
 rtl/data_mem_pkg.sv | 26 ++
 rtl/data_mem_bridge_stats.sv | 41 ++++
 rtl/data_mem_bridge.sv | 76 +++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared widths, response-stage record and window check for data_mem_bridge
package data_mem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef struct packed {
        logic valid;
        logic err;
        logic we;
    } mem_rsp_t;

    // True when addr falls inside [base, base + depth*4), with the subtraction
    // wrapping at aw bits so that addresses below base miss.
    function automatic logic in_window(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] depth,
        input int unsigned aw
    );
        logic [63:0] mask;
        mask = (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
        return ((addr - base) & mask) < (depth << 2);
    endfunction

endpackage

// File: rtl/data_mem_bridge_stats.sv
// data_mem_bridge_stats: saturating read-hit / write-hit / miss counters
module data_mem_bridge_stats
    import data_mem_pkg::*;
(
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              rd_inc_i,
    input  logic              wr_inc_i,
    input  logic              err_inc_i,
    output logic [DATA_W-1:0] stat_rd_o,
    output logic [DATA_W-1:0] stat_wr_o,
    output logic [DATA_W-1:0] stat_err_o
);

    logic [DATA_W-1:0] rd_q, rd_d, wr_q, wr_d, err_q, err_d;

    // Each counter steps by one per event and sticks at all-ones
    always_comb begin
        rd_d  = (rd_inc_i  && rd_q  != '1) ? rd_q  + DATA_W'(1) : rd_q;
        wr_d  = (wr_inc_i  && wr_q  != '1) ? wr_q  + DATA_W'(1) : wr_q;
        err_d = (err_inc_i && err_q != '1) ? err_q + DATA_W'(1) : err_q;
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            err_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            err_q <= err_d;
        end
    end

    assign stat_rd_o  = rd_q;
    assign stat_wr_o  = wr_q;
    assign stat_err_o = err_q;

endmodule

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: LSU req/gnt/rvalid port to 1-cycle byte-writable BRAM; optional counters via DATA_MEM_BRIDGE_STATS_EN
module data_mem_bridge
    import data_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    RAM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    localparam int                   RAM_AW     = $clog2(RAM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [BE_W-1:0]       data_be_i,
    input  logic [DATA_W-1:0]     data_wdata_i,
    output logic [DATA_W-1:0]     data_rdata_o,
    output logic                  data_err_o,
    output logic                  ram_en_o,
    output logic [BE_W-1:0]       ram_we_o,
    output logic [RAM_AW-1:0]     ram_addr_o,
    output logic [DATA_W-1:0]     ram_wdata_o,
    input  logic [DATA_W-1:0]     ram_rdata_i
`ifdef DATA_MEM_BRIDGE_STATS_EN
   ,output logic [DATA_W-1:0]     stat_rd_o,
    output logic [DATA_W-1:0]     stat_wr_o,
    output logic [DATA_W-1:0]     stat_err_o
`endif
);

    logic     hit, acc;
    mem_rsp_t rsp_q, rsp_d;

    // No backpressure: every request is granted; a hit also drives the RAM port.
    // BASE_ADDR is aligned to the window size, so the word index only needs
    // the low address bits.
    always_comb begin
        hit         = in_window(64'(data_addr_i), 64'(BASE_ADDR), 64'(RAM_DEPTH), ADDR_WIDTH);
        data_gnt_o  = data_req_i;
        acc         = data_req_i & hit;
        ram_en_o    = acc;
        ram_we_o    = (acc & data_we_i) ? data_be_i : '0;
        ram_addr_o  = data_addr_i[RAM_AW+1:2] - BASE_ADDR[RAM_AW+1:2];
        ram_wdata_o = data_wdata_i;
        rsp_d       = '{valid: data_req_i, err: data_req_i & ~hit, we: data_we_i};
    end

    // Single response stage; reset drops any in-flight response
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rsp_q <= '0;
        else         rsp_q <= rsp_d;
    end

    // Response lines line up with the RAM read data one cycle after the grant
    always_comb begin
        data_rvalid_o = rsp_q.valid;
        data_err_o    = rsp_q.valid & rsp_q.err;
        data_rdata_o  = (rsp_q.valid & ~rsp_q.err & ~rsp_q.we) ? ram_rdata_i : '0;
    end

`ifdef DATA_MEM_BRIDGE_STATS_EN
    data_mem_bridge_stats u_stats (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .rd_inc_i   (acc & ~data_we_i),
        .wr_inc_i   (acc & data_we_i),
        .err_inc_i  (data_req_i & ~hit),
        .stat_rd_o  (stat_rd_o),
        .stat_wr_o  (stat_wr_o),
        .stat_err_o (stat_err_o)
    );
`endif

endmodule
